// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory access controller
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_e;

    // Funct3[1:0] encodes the access size, Funct3[2] selects zero-extension
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;
    localparam int F3_UNSIGNED_BIT = 2;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/grant/response data-memory port
interface dmem_if #(
    parameter int XLEN = 64,
    parameter int BE_W = XLEN / 8
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane alignment, byte enables and load extension
module lsu_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BE_W = XLEN / 8
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic            aligned,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata_ext
);

    logic [1:0]      sz;
    logic            uns;
    logic [15:0]     be_base;
    logic [15:0]     be_wide;
    logic [XLEN-1:0] shifted;

    assign sz       = funct3[1:0];
    assign uns      = funct3[F3_UNSIGNED_BIT];
    assign be_base  = (16'd1 << size_bytes(sz)) - 16'd1;
    assign be_wide  = be_base << offset;
    assign be       = be_wide[BE_W-1:0];
    assign wdata_sh = wdata << {offset, 3'b000};
    assign shifted  = rdata >> {offset, 3'b000};

    // natural alignment: low address bits below the access size must be zero
    always_comb begin
        aligned = 1'b0;
        case (sz)
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~offset[0];
            SZ_W:    aligned = (offset[1:0] == 2'b00);
            default: aligned = (offset == 3'b000);
        endcase
    end

    // pick the addressed bytes out of the lane-shifted word and extend
    always_comb begin
        rdata_ext = shifted;
        case (sz)
            SZ_B:    rdata_ext = {{(XLEN-8){shifted[7] & ~uns}}, shifted[7:0]};
            SZ_H:    rdata_ext = {{(XLEN-16){shifted[15] & ~uns}}, shifted[15:0]};
            SZ_W:    rdata_ext = {{(XLEN-32){shifted[31] & ~uns}}, shifted[31:0]};
            SZ_D:    rdata_ext = shifted;
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - M-stage load/store sequencer with pipeline stall
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemRead_M,
    input  logic            MemWrite_M,
    input  logic [2:0]      Funct3_M,
    input  logic [XLEN-1:0] ALUResult_M,
    input  logic [XLEN-1:0] WriteData_M,
    output logic [XLEN-1:0] ReadData_M,
    output logic            Misaligned_M,
    output logic            Stall_Mem,
    dmem_if.master          mem_bus
);

    dmem_state_e     state;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_ext;
    logic            access;
    logic            aligned;
    logic            issue;

    lsu_align #(
        .XLEN (XLEN),
        .BE_W (BE_W)
    ) u_align (
        .funct3    (Funct3_M),
        .offset    (ALUResult_M[2:0]),
        .wdata     (WriteData_M),
        .rdata     (rdata_q),
        .aligned   (aligned),
        .be        (mem_bus.mem_be),
        .wdata_sh  (mem_bus.mem_wdata),
        .rdata_ext (rdata_ext)
    );

    assign access = MemRead_M | MemWrite_M;
    assign issue  = (state == IDLE) && access && aligned;

    // request fields follow M directly; the stall keeps M frozen until grant
    assign mem_bus.mem_req  = issue || (state == REQ);
    assign mem_bus.mem_we   = MemWrite_M;
    assign mem_bus.mem_addr = {ALUResult_M[XLEN-1:3], 3'b000};

    assign Stall_Mem    = issue || (state == REQ) || (state == WAIT);
    assign Misaligned_M = access && !aligned;
    // stores win when both strobes are set, and they return no data
    assign ReadData_M   = ((state == DONE) && !MemWrite_M) ? rdata_ext : '0;

    // one outstanding access: issue, wait for grant, wait for response, release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (issue) state <= mem_bus.mem_gnt ? WAIT : REQ;
                REQ:  if (mem_bus.mem_gnt) state <= WAIT;
                WAIT: begin
                    if (mem_bus.mem_rvalid) begin
                        rdata_q <= mem_bus.mem_rdata;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller for the Memory stage of the RV64I/Zba pipeline. Sequences every load and store in M onto a variable-latency request/grant/response memory port, aligns store data and byte enables, sign/zero-extends load data, and raises a global pipeline stall while an access is outstanding. It sits between the M-stage pipeline register and the data memory, and its stall output is OR-ed into the stall/flush network driven by the hazard unit.

## Interface
Parameters:
- XLEN, 64, datapath and address width
- BE_W, XLEN/8, byte-enable width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- MemRead_M  in  1  load instruction in M
- MemWrite_M  in  1  store instruction in M
- Funct3_M  in  3  access size/sign (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu)
- ALUResult_M  in  XLEN  effective byte address
- WriteData_M  in  XLEN  store data (LSBs valid)
- ReadData_M  out  XLEN  extended load result, valid in DONE
- Misaligned_M  out  1  access not naturally aligned; suppressed
- Stall_Mem  out  1  freeze F/D/E/M, bubble into W
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  XLEN  doubleword-aligned address (addr[2:0] = 0)
- mem_be  out  BE_W  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response (load data or write ack)
- mem_rdata  in  XLEN  response data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if (MemRead_M|MemWrite_M) and aligned: mem_req=1, Stall_Mem=1; mem_gnt=1 -> WAIT, else -> REQ. If misaligned: Misaligned_M=1, no request, no stall, stay IDLE. No access: stay IDLE.
- REQ: mem_req=1, Stall_Mem=1; on mem_gnt -> WAIT.
- WAIT: mem_req=0, Stall_Mem=1; on mem_rvalid capture mem_rdata into rdata_q -> DONE.
- DONE: Stall_Mem=0, no request; ReadData_M from rdata_q; -> IDLE unconditionally (pipeline advances this cycle, so the same instruction is never reissued).
- Request fields are combinational from M inputs; stall freezes M so they remain stable REQ->grant. mem_we=MemWrite_M.
- Size bytes n = 1<<Funct3_M[1:0]; aligned iff addr mod n = 0. mem_be = ((1<<n)-1) << addr[2:0]; mem_wdata = WriteData_M << 8*addr[2:0]; mem_addr = {addr[XLEN-1:3],3'b000}.
- Load: shifted = rdata_q >> 8*addr[2:0]; Funct3_M[2]=0 sign-extend, 1 zero-extend from n bytes; 011 passes 64 bits.
- Stores also wait for mem_rvalid (ack); mem_rdata ignored, ReadData_M = 0.
- MemRead_M and MemWrite_M both 1: treat as store.
- mem_rvalid outside WAIT ignored. mem_gnt outside request cycles ignored.

## Timing
- Reset (async, rst_n=0): state IDLE, rdata_q=0; all outputs combinational of IDLE: mem_req=0 unless M access present after release; Stall_Mem=0, ReadData_M=0, Misaligned_M=0 with no access. Outstanding transaction dropped; memory is reset with the core.
- Best case: gnt in issue cycle t, rvalid at t+1 -> DONE at t+2; Stall_Mem high t, t+1 (2 stall cycles). Each gnt delay cycle and rvalid delay cycle adds one.
- ReadData_M valid only in DONE; W-stage register samples it at end of DONE.
- Back-to-back accesses: next M instruction issues in the cycle after DONE; at most one outstanding transaction.
- Misaligned_M purely combinational, same cycle, zero latency.

## Structure
- Shared package dmem_pkg: state enum (IDLE/REQ/WAIT/DONE), Funct3 load/store size constants.
- Sub-module lsu_align (combinational): byte-enable generation, store lane shift, load shift and extension, alignment check. FSM and rdata_q stay in dmem_ctrl.

## Test plan
- LD at 0x1000, gnt at t, rvalid at t+1 with rdata 0x1122334455667788 -> Stall_Mem high 2 cycles, ReadData_M=0x1122334455667788 in DONE.
- LB at 0x1003, rdata 0x00000000_80000000 -> mem_be=0x08, ReadData_M=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
- SH at 0x2006 data 0xBEEF, gnt delayed 3 cycles -> mem_req held 4 cycles with stable addr 0x2000, be=0xC0, wdata=0xBEEF000000000000; stall ends after ack.
- LW at 0x3002 -> Misaligned_M=1, mem_req=0, Stall_Mem=0.
- Two consecutive loads -> second mem_req asserted exactly one cycle after first DONE; no duplicate request for first.
- rst_n low during WAIT -> state IDLE immediately, Stall_Mem=0; late mem_rvalid after release ignored.
